dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning request address width in bits.
REQ-002 SHALL have parameter DW, default 32, meaning data width in bits.
REQ-003 SHALL have parameter DEPTH, default 128, meaning number of valid memory words; legal addresses are 0..DEPTH-1.
REQ-004 SHALL have one clock and reset is asynchronous and active-low: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide, for each requester port p in {0,1}, these signals: p0 is the CPU load/store unit and p1 is the DMA/debug loader.
- reqp_valid  input  1  request present
- reqp_ready  output  1  request accepted this cycle
- reqp_we  input  1  1 = write, 0 = read
- reqp_addr  input  AW  word address
- reqp_wdata  input  DW  write data
- rspp_valid  output  1  one-cycle response pulse
- rspp_rdata  output  DW  read data
- rspp_err  output  1  address out of range
REQ-006 SHALL drive the memory port as follows: mem_a  output  AW  address; mem_di  output  DW  write data; mem_we  output  1  write enable; mem_do  input  DW  combinational read data.

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-008 IDLE: if any reqp_valid, SHALL assert ready to exactly one winner, latch its we/addr/wdata and port id, and go to ACCESS; otherwise SHALL stay in IDLE.
REQ-009 Arbitration SHALL be round-robin: on a tie, the port not granted last wins; after reset, p0 has priority.
REQ-010 ACCESS (one cycle): SHALL drive mem_a = latched addr; mem_we = latched we AND addr < DEPTH; mem_di = latched wdata; SHALL capture mem_do into an rdata register; SHALL go to RESP.
REQ-011 RESP: SHALL pulse rspp_valid for the granted port only, with rspp_rdata = captured data (0 for writes) and rspp_err = (addr >= DEPTH); SHALL return to IDLE.
REQ-012 Out-of-range requests SHALL never assert mem_we, and the read response SHALL return 0 with err=1.
REQ-013 Latency SHALL be fixed: accept in cycle N, mem access in N+1, response in N+2; throughput is one request per 3 cycles.
REQ-014 mem_we SHALL be high only in ACCESS; outside ACCESS, mem_a, mem_di and mem_we SHALL be 0.
REQ-015 reqp_ready SHALL be asserted only in IDLE, and is combinational from reqp_valid and the priority state.
REQ-016 The losing requester SHALL hold its request (valid-stable rule); the block SHALL not drop it, and it SHALL win the next IDLE.
REQ-017 A request for the same address as the previous write SHALL return the new data (no forwarding required, because accesses serialise).
REQ-018 rsp outputs of the non-granted port SHALL be 0.

Reset
REQ-019 rst_n low SHALL force state IDLE, priority to p0, all ready/rsp outputs 0, mem_we 0 and latched registers 0, asynchronously.
REQ-020 Reset asserted mid-ACCESS SHALL abort the access: no response is issued after release, and mem_we drops immediately.
REQ-021 The first grant SHALL be possible in the first rising edge with rst_n high.

Structure
REQ-022 A shared package SHALL hold the state enum (IDLE/ACCESS/RESP), the PORT_CPU/PORT_DMA constants and the default DEPTH.
REQ-023 The round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs: two requests and last grant; output: one-hot grant).
REQ-024 The memory SHALL be external to this block.

Verification
REQ-025 p0 writes 0x00000258 to addr 0x60, then reads addr 0x60: the read responds 2 cycles after accept with rdata 0x00000258 and err 0.
REQ-026 p0 and p1 both read in the same cycle after reset: p0 is granted first and p1 is granted on the next IDLE; each receives exactly one rsp pulse.
REQ-027 p0 and p1 hold valid continuously for 6 grants: grants alternate p0,p1,p0,p1,p0,p1.
REQ-028 p1 writes 0xdeadbeef to addr 0x80 (DEPTH=128): mem_we stays 0, rsp1_err=1, and a subsequent read of addr 0x00 is unchanged.
REQ-029 Assert rst_n low during ACCESS of a write: mem_we falls immediately, no rsp pulse follows, and the state is IDLE with p0 priority.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int DEFAULT_DEPTH = 128;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one requester of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin grant: on a tie the port not granted last wins.
module rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            gnt = (last_gnt == PORT_CPU) ? 2'b10 : 2'b01;
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CPU (p0) and DMA (p1) requests onto one external memory port,
// with fixed accept -> access -> response latency.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_di,
    output logic          mem_we,
    input  logic [DW-1:0] mem_do
);

    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    state_t        state, state_nxt;
    logic          last_gnt;
    logic          lat_port;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] rdata_q;
    logic [1:0]    gnt;
    logic          accept;
    logic          in_range;

    assign in_range = ({1'b0, lat_addr} < DEPTH_LIM);

    rr_arbiter2 u_rr (
        .req0     (p0.req_valid),
        .req1     (p1.req_valid),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // last_gnt resets to the DMA port so the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= PORT_DMA;
            lat_port  <= PORT_CPU;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                lat_port  <= gnt[1];
                last_gnt  <= gnt[1];
                lat_we    <= gnt[1] ? p1.req_we    : p0.req_we;
                lat_addr  <= gnt[1] ? p1.req_addr  : p0.req_addr;
                lat_wdata <= gnt[1] ? p1.req_wdata : p0.req_wdata;
            end
            if (state == ACCESS) begin
                rdata_q <= (in_range && !lat_we) ? mem_do : '0;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        mem_a        = '0;
        mem_di       = '0;
        mem_we       = 1'b0;
        p0.req_ready = 1'b0;
        p1.req_ready = 1'b0;
        p0.rsp_valid = 1'b0;
        p0.rsp_rdata = '0;
        p0.rsp_err   = 1'b0;
        p1.rsp_valid = 1'b0;
        p1.rsp_rdata = '0;
        p1.rsp_err   = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && (gnt != 2'b00)) begin
                    accept       = 1'b1;
                    p0.req_ready = gnt[0];
                    p1.req_ready = gnt[1];
                    state_nxt    = ACCESS;
                end
            end
            ACCESS: begin
                mem_a     = lat_addr;
                mem_di    = lat_wdata;
                mem_we    = lat_we && in_range;
                state_nxt = RESP;
            end
            RESP: begin
                if (lat_port == PORT_CPU) begin
                    p0.rsp_valid = 1'b1;
                    p0.rsp_rdata = rdata_q;
                    p0.rsp_err   = !in_range;
                end else begin
                    p1.rsp_valid = 1'b1;
                    p1.rsp_rdata = rdata_q;
                    p1.rsp_err   = !in_range;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 128-word behavioural memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_a;
    logic [31:0] mem_di;
    logic        mem_we;
    logic [31:0] mem_do;
    logic [31:0] mem [0:127];
    int          tests;
    int          fails;
    int          cnt0;
    int          cnt1;
    int          c0;
    int          c1;

    dmem_arbiter_if #(.AW(32), .DW(32)) if0 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) if1 ();

    dmem_arbiter #(.AW(32), .DW(32), .DEPTH(128)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .p0     (if0),
        .p1     (if1),
        .mem_a  (mem_a),
        .mem_di (mem_di),
        .mem_we (mem_we),
        .mem_do (mem_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Out-of-range reads return junk so the block must mask it.
    assign mem_do = (mem_a < 32'd128) ? mem[mem_a[6:0]] : 32'hbad0bad0;

    always @(posedge clk) begin
        if (mem_we && (mem_a < 32'd128)) mem[mem_a[6:0]] <= mem_di;
        cnt0 <= cnt0 + (if0.rsp_valid ? 1 : 0);
        cnt1 <= cnt1 + (if1.rsp_valid ? 1 : 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit port, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 1'b0) begin
            if0.req_valid = v; if0.req_we = we; if0.req_addr = addr; if0.req_wdata = wdata;
        end else begin
            if1.req_valid = v; if1.req_we = we; if1.req_addr = addr; if1.req_wdata = wdata;
        end
    endtask

    // Single transaction from an IDLE negedge with the other port quiet.
    task automatic xact(input bit port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rexp,
                        input logic eexp, input string tag);
        drive(port, 1'b1, we, addr, wdata);
        #1;
        chk({tag, ".ready"},  port ? if1.req_ready : if0.req_ready, 32'd1);
        chk({tag, ".oready"}, port ? if0.req_ready : if1.req_ready, 32'd0);
        @(negedge clk);
        drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
        chk({tag, ".mem_we"}, mem_we, {31'd0, we && !eexp});
        chk({tag, ".mem_a"},  mem_a,  addr);
        chk({tag, ".mem_di"}, mem_di, wdata);
        @(negedge clk);
        chk({tag, ".rsp_v"},  port ? if1.rsp_valid : if0.rsp_valid, 32'd1);
        chk({tag, ".orsp_v"}, port ? if0.rsp_valid : if1.rsp_valid, 32'd0);
        chk({tag, ".rdata"},  port ? if1.rsp_rdata : if0.rsp_rdata, rexp);
        chk({tag, ".err"},    port ? if1.rsp_err   : if0.rsp_err,   {31'd0, eexp});
        @(negedge clk);
        chk({tag, ".idle_we"}, mem_we, 32'd0);
        chk({tag, ".idle_a"},  mem_a,  32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cnt0  = 0;
        cnt1  = 0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000 + i;
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h1);
        drive(1'b1, 1'b1, 1'b1, 32'h11, 32'h2);
        repeat (2) @(negedge clk);

        // Reset state, with both requesters pushing.
        chk("rst.ready0", if0.req_ready, 32'd0);
        chk("rst.ready1", if1.req_ready, 32'd0);
        chk("rst.rsp0",   if0.rsp_valid, 32'd0);
        chk("rst.rsp1",   if1.rsp_valid, 32'd0);
        chk("rst.mem_we", mem_we, 32'd0);
        chk("rst.mem_a",  mem_a,  32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b1;

        // Write then read back on p0; first grant on the first edge after reset.
        xact(1'b0, 1'b1, 32'h60, 32'h258, 32'h0,   1'b0, "wr60");
        xact(1'b0, 1'b0, 32'h60, 32'h0,   32'h258, 1'b0, "rd60");

        // Simultaneous reads right after reset: p0 first, then p1.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        c0 = cnt0;
        c1 = cnt1;
        drive(1'b0, 1'b1, 1'b0, 32'h60, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        chk("tie.ready0", if0.req_ready, 32'd1);
        chk("tie.ready1", if1.req_ready, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("tie.acc_a0", mem_a, 32'h60);
        @(negedge clk);
        chk("tie.rsp0",   if0.rsp_valid, 32'd1);
        chk("tie.rdata0", if0.rsp_rdata, 32'h258);
        chk("tie.rsp1_0", if1.rsp_valid, 32'd0);
        chk("tie.rdat1_0", if1.rsp_rdata, 32'd0);
        @(negedge clk);
        chk("tie.ready1b", if1.req_ready, 32'd1);
        chk("tie.ready0b", if0.req_ready, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("tie.acc_a1", mem_a, 32'h10);
        @(negedge clk);
        chk("tie.rsp1",   if1.rsp_valid, 32'd1);
        chk("tie.rdata1", if1.rsp_rdata, 32'h1010);
        chk("tie.rsp0_1", if0.rsp_valid, 32'd0);
        repeat (2) @(negedge clk);
        chk("tie.cnt0", cnt0 - c0, 32'd1);
        chk("tie.cnt1", cnt1 - c1, 32'd1);

        // Both held valid for six grants: strict alternation starting at p0.
        c0 = cnt0;
        c1 = cnt1;
        drive(1'b0, 1'b1, 1'b0, 32'h1, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h2, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr%0d.ready0", i), if0.req_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d.ready1", i), if1.req_ready, (i % 2 == 1) ? 32'd1 : 32'd0);
            repeat (3) @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rr.cnt0", cnt0 - c0, 32'd3);
        chk("rr.cnt1", cnt1 - c1, 32'd3);

        // Out-of-range and last-word boundary accesses.
        xact(1'b1, 1'b1, 32'h80,  32'hdeadbeef, 32'h0,      1'b1, "wr80");
        xact(1'b0, 1'b0, 32'h0,   32'h0,        32'h1000,   1'b0, "rd00");
        xact(1'b1, 1'b1, 32'h7f,  32'hcafef00d, 32'h0,      1'b0, "wr7f");
        xact(1'b0, 1'b0, 32'h7f,  32'h0,        32'hcafef00d, 1'b0, "rd7f");
        xact(1'b0, 1'b0, 32'h200, 32'h0,        32'h0,      1'b1, "rd200");

        // Reset during the ACCESS cycle of a p0 write.
        c0 = cnt0;
        c1 = cnt1;
        drive(1'b0, 1'b1, 1'b1, 32'h5, 32'h5555);
        #1;
        chk("abt.ready0", if0.req_ready, 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("abt.we_pre", mem_we, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abt.we_rst", mem_we, 32'd0);
        chk("abt.a_rst",  mem_a,  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abt.cnt0", cnt0 - c0, 32'd0);
        chk("abt.cnt1", cnt1 - c1, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h5, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h6, 32'h0);
        #1;
        chk("abt.prio0", if0.req_ready, 32'd1);
        chk("abt.prio1", if1.req_ready, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("abt.rdata5", if0.rsp_rdata, 32'h1005);
        @(negedge clk);
        chk("abt.ready1", if1.req_ready, 32'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("abt.rdata6", if1.rsp_rdata, 32'h1006);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
